mmio_register_bank: RTL

- MMIO responder that terminates an `mmio_if.device` link, for example the `device_interface` side of the MMIO buffer.
- Holds NUM_RW read/write configuration registers that drive the fabric, and exposes NUM_RO read-only status inputs.
- Reads use a four-phase req/ack handshake with programmable latency. Writes use a same-cycle req/ack handshake with stall backpressure.
- Sits at the leaf of the MMIO tree, in front of PE and router configuration state.

---
 rtl/mmio_register_bank_if.sv | 25 ++
 rtl/mmio_register_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mmio_register_bank_if.sv
// MMIO link between an initiator (host) and a responder (device): four-phase
// reads, same-cycle-acked writes.
interface mmio_if #(
  parameter int unsigned INDEX_WIDTH = 32,
  parameter int unsigned DATA_WIDTH  = 32
);
  logic                   read_req;
  logic [INDEX_WIDTH-1:0] read_index;
  logic                   read_ack;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   write_req;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   write_ack;

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );
endinterface

// File: rtl/mmio_register_bank.sv
// Leaf MMIO responder: NUM_RW config registers driving the fabric plus NUM_RO
// read-only status words, with a programmable-latency read FSM.
module mmio_register_bank #(
  parameter int unsigned INDEX_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_RW       = 8,
  parameter int unsigned NUM_RO       = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  mmio_if.device                       host_interface,
  input  logic                         write_stall,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW*DATA_WIDTH-1:0] config_out,
  output logic [NUM_RW-1:0]            write_strobe,
  output logic                         index_error
);

  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_LIMIT = INDEX_WIDTH'(NUM_RW + NUM_RO);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0]         ridx_q, ridx_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [NUM_RW*DATA_WIDTH-1:0]   cfg_q, cfg_d;
  logic [NUM_RW-1:0]              strobe_q, strobe_d;
  logic                           err_q, err_d;

  logic                           wr_fire;
  logic                           wr_oor;
  logic                           rd_load;
  logic                           rd_oor;
  logic [INDEX_WIDTH-1:0]         rd_sel;
  logic [DATA_WIDTH-1:0]          rd_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ridx_q   <= '0;
      rdata_q  <= '0;
      cfg_q    <= {NUM_RW{RESET_VALUE}};
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ridx_q   <= ridx_d;
      rdata_q  <= rdata_d;
      cfg_q    <= cfg_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  // Write channel: commit on the edge where the ack is high.
  always_comb begin
    wr_fire  = host_interface.write_req && !write_stall;
    cfg_d    = cfg_q;
    strobe_d = '0;
    wr_oor   = 1'b0;
    if (wr_fire) begin
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        if (host_interface.write_index == INDEX_WIDTH'(i)) begin
          cfg_d[i*DATA_WIDTH +: DATA_WIDTH] = host_interface.write_data;
          strobe_d[i] = 1'b1;
        end
      end
      wr_oor = (host_interface.write_index >= IDX_LIMIT);
    end
  end

  // In IDLE the live index is used so READ_LATENCY=1 can load on the request edge.
  always_comb begin
    rd_sel  = (state_q == ST_IDLE) ? host_interface.read_index : ridx_q;
    rd_word = '0;
    rd_oor  = (rd_sel >= IDX_LIMIT);
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (rd_sel == INDEX_WIDTH'(i)) rd_word = cfg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (rd_sel == INDEX_WIDTH'(NUM_RW + k)) rd_word = status_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    rdata_d = rdata_q;
    rd_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (host_interface.read_req) begin
          ridx_d = host_interface.read_index;
          if (LAT_M1 == '0) begin
            state_d = ST_ACK;
            rd_load = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACK;
          rd_load = 1'b1;
        end
      end
      ST_ACK: begin
        if (!host_interface.read_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rd_load) rdata_d = rd_word;
    err_d = err_q | wr_oor | (rd_load & rd_oor);
  end

  always_comb begin
    host_interface.read_ack  = (state_q == ST_ACK);
    host_interface.read_data = rdata_q;
    host_interface.write_ack = wr_fire;
    config_out               = cfg_q;
    write_strobe             = strobe_q;
    index_error              = err_q;
  end

endmodule
